instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//   IF stage: generates the sequential fetch PC and drives the instruction-memory req/ack port.
//   Buffers returned words in a small {pc,instr} FIFO and presents them to the ID stage with o_ce.
//   Honours the ID stall. Redirects to the branch/jump target on the ID flush (i_flush/i_branch_pc).
// PARAMETERS
//   RESET_PC   32'h0000_0000  first fetch address after reset
//   BUF_DEPTH  2              FIFO entries (power of 2, >=2)
// PORTS
//   clk            in   1   clock
//   rst_n          in   1   reset, synchronous, active-low
//   o_imem_req     out  1   fetch request; held high until i_imem_ack
//   o_imem_addr    out  32  fetch address, word aligned ([1:0]=0); stable while req && !ack
//   i_imem_ack     in   1   read data valid this cycle; completes the outstanding request
//   i_imem_data    in   32  instruction word, valid with i_imem_ack
//   i_stall        in   1   ID cannot accept: hold current output
//   i_flush        in   1   branch/jump taken in ID: discard fetched work, redirect
//   i_branch_pc    in   32  redirect target, sampled when i_flush=1 ([1:0] ignored)
//   o_instr        out  32  instruction to ID (FIFO head)
//   o_pc           out  32  PC of o_instr
//   o_ce           out  1   o_instr/o_pc valid (FIFO not empty)
// BEHAVIOUR
//   Reset (clk edge with rst_n=0): state=IDLE, fetch_pc=RESET_PC, FIFO empty, o_imem_req=0, o_ce=0,
//     o_instr=32'h0000_0013 (NOP), o_pc=RESET_PC. Reset aborts any transaction; ack while req=0 ignored.
//   FSM:
//     IDLE  -> FETCH after 1 cycle.
//     FETCH: req = (count<BUF_DEPTH) || waiting; addr = fetch_pc.
//            On ack: push {fetch_pc,data}; fetch_pc += 4 (wraps 32'hFFFF_FFFC -> 0).
//     DRAIN: req held high with the old addr. On ack: data discarded -> FETCH.
//   One request outstanding max. Zero-wait ack (same cycle as req) allowed.
//     With zero-wait ack and no stall, sustains 1 instr/cycle.
//   Flush (priority over stall, pop and push):
//     Next edge: FIFO cleared, o_ce=0, fetch_pc={i_branch_pc[31:2],2'b00}.
//     Request outstanding and not acked this cycle -> DRAIN.
//     Acked the same cycle, or no request outstanding -> FETCH; new req to target next cycle.
//     Flush while in DRAIN: target updated, stay DRAIN.
//   Pop when o_ce && !i_stall && !i_flush. Push and pop in the same cycle keep count unchanged.
//   Output hold: o_instr/o_pc change only on pop or push-into-empty.
//     When FIFO is empty they keep their last value.
//   Full: no new req raised when count==BUF_DEPTH. A held req never overflows
//     (space was reserved when it was raised).
//   No combinational path i_stall/i_flush -> o_ce/o_instr/o_pc; those are registered.
//     o_imem_req depends only on state/count.
// TESTING
//   1 Reset release, zero-wait memory, no stall
//       -> addr 0,4,8,... on consecutive cycles; o_ce=1 from cycle 2; o_pc 0,4,8 in order.
//   2 Memory ack latency 3
//       -> addr stable 3 cycles per request; one instr every 3 cycles; o_ce gaps; no duplicates.
//   3 Stall held 5 cycles, zero-wait memory
//       -> FIFO fills to 2, req drops; o_instr/o_pc frozen.
//       On release: next two PCs in order, no loss, then fetching resumes.
//   4 Flush to 0x100 with a 2-cycle outstanding request at 0x20
//       -> 0x20 response discarded; next req addr 0x100; first o_pc after flush 0x100.
//   5 Flush coincident with ack and with stall
//       -> acked word dropped, FIFO emptied, next req 0x200; branch_pc 0x203 -> addr 0x200.
//   6 rst_n low mid-wait, then release
//       -> req drops immediately; late ack ignored; fetch restarts at RESET_PC; o_instr=NOP until valid.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: sequential PC generation, single-outstanding
// instruction-memory request, {pc,instr} buffer toward decode, and
// redirect on a decode-stage flush.
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_data,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic [31:0] i_branch_pc,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic        o_ce
);

    localparam int unsigned AW = $clog2(BUF_DEPTH);
    localparam int unsigned CW = $clog2(BUF_DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t        state;
    logic [31:0]   fetch_pc;
    logic [31:0]   drain_addr;
    logic [31:0]   pc_mem    [BUF_DEPTH];
    logic [31:0]   instr_mem [BUF_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_next;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          push;
    logic          pop;

    // Request/address decode. A request raised while count<BUF_DEPTH stays
    // raised until acked because count cannot grow without that ack, so the
    // slot it needs is already reserved.
    always_comb begin
        o_imem_req  = ((state == FETCH) && (count < FULL)) || (state == DRAIN);
        o_imem_addr = (state == DRAIN) ? drain_addr : fetch_pc;
        push        = (state == FETCH) && o_imem_req && i_imem_ack;
        pop         = o_ce && !i_stall;
        rd_next     = rd_ptr + AW'(1);
        count_next  = count;
        if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (!push && pop) begin
            count_next = count - CW'(1);
        end
    end

    // Fetch control FSM: state, next fetch address, and the address held
    // while draining a request made stale by a flush.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            fetch_pc   <= RESET_PC;
            drain_addr <= RESET_PC;
        end else if (i_flush) begin
            fetch_pc <= i_branch_pc & 32'hFFFF_FFFC;
            case (state)
                IDLE:  state <= FETCH;
                FETCH: begin
                    if (o_imem_req && !i_imem_ack) begin
                        state      <= DRAIN;
                        drain_addr <= fetch_pc;
                    end
                end
                DRAIN: begin
                    if (i_imem_ack) begin
                        state <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end else begin
            case (state)
                IDLE:  state <= FETCH;
                FETCH: begin
                    if (push) begin
                        fetch_pc <= fetch_pc + 32'd4;
                    end
                end
                DRAIN: begin
                    if (i_imem_ack) begin
                        state <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Buffer and registered decode-facing outputs. The head is kept in
    // o_pc/o_instr, so it only moves on a pop or on a push into empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            o_ce    <= 1'b0;
            o_instr <= NOP;
            o_pc    <= RESET_PC;
        end else if (i_flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            o_ce   <= 1'b0;
        end else begin
            if (push) begin
                pc_mem[wr_ptr]    <= fetch_pc;
                instr_mem[wr_ptr] <= i_imem_data;
                wr_ptr            <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_next;
                if (count > CW'(1)) begin
                    o_pc    <= pc_mem[rd_next];
                    o_instr <= instr_mem[rd_next];
                end else if (push) begin
                    o_pc    <= fetch_pc;
                    o_instr <= i_imem_data;
                end
            end else if (push && (count == '0)) begin
                o_pc    <= fetch_pc;
                o_instr <= i_imem_data;
            end
            count <= count_next;
            o_ce  <= (count_next != '0);
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: directed scenarios plus randomized stall, flush,
// memory latency and reset, checked against a stream-level reference model.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ack;
    logic [31:0] i_imem_data;
    logic        i_stall;
    logic        i_flush;
    logic [31:0] i_branch_pc;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic        o_ce;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
        .i_imem_ack(i_imem_ack), .i_imem_data(i_imem_data),
        .i_stall(i_stall), .i_flush(i_flush), .i_branch_pc(i_branch_pc),
        .o_instr(o_instr), .o_pc(o_pc), .o_ce(o_ce)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: expected decode stream and expected next
    // request address, plus memory-side bookkeeping.
    logic [31:0] exp_pc, next_fetch, pend_addr, hold_pc, hold_instr;
    logic        pending, cur_stale, chk_ce0, chk_hold;
    int          m_lat, m_cnt;
    int          fixed_lat = 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic model_reset();
        exp_pc     = 32'h0;
        next_fetch = 32'h0;
        pending    = 1'b0;
        cur_stale  = 1'b0;
        chk_ce0    = 1'b0;
        chk_hold   = 1'b0;
        m_cnt      = 0;
    endtask

    // Synchronous reset for two edges; optionally with ack held high to show
    // that a late or spurious ack is ignored.
    task automatic do_reset(input logic late_ack);
        rst_n      = 1'b0;
        i_stall    = 1'b0;
        i_flush    = 1'b0;
        i_imem_ack = late_ack;
        i_imem_data = 32'hDEAD_BEEF;
        @(posedge clk); @(negedge clk);
        check("rst_req", 32'(o_imem_req), 32'd0);
        check("rst_ce", 32'(o_ce), 32'd0);
        check("rst_instr", o_instr, 32'h0000_0013);
        check("rst_pc", o_pc, 32'h0);
        @(posedge clk); @(negedge clk);
        rst_n      = 1'b1;
        i_imem_ack = 1'b0;
        model_reset();
    endtask

    // One clock cycle: check results of the previous edge, drive memory and
    // decode-side inputs, advance the reference model, then clock.
    task automatic cycle(input logic stall, input logic flush, input logic [31:0] bpc);
        logic req, ack;
        if (chk_ce0) check("ce_after_flush", 32'(o_ce), 32'd0);
        if (chk_hold) begin
            check("hold_ce", 32'(o_ce), 32'd1);
            check("hold_pc", o_pc, hold_pc);
            check("hold_instr", o_instr, hold_instr);
        end
        chk_ce0  = 1'b0;
        chk_hold = 1'b0;
        req = o_imem_req;
        if (req) begin
            check("addr_align", 32'(o_imem_addr[1:0]), 32'd0);
            if (pending) begin
                check("addr_stable", o_imem_addr, pend_addr);
            end else begin
                check("req_addr", o_imem_addr, next_fetch);
                pend_addr = o_imem_addr;
                cur_stale = 1'b0;
                m_cnt     = 0;
                m_lat     = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
            end
            ack = (m_cnt == m_lat - 1);
        end else begin
            ack = ($urandom_range(0, 7) == 0);
        end
        i_imem_ack  = ack;
        i_imem_data = (req && ack) ? mem_word(o_imem_addr) : $urandom;
        i_stall     = stall;
        i_flush     = flush;
        i_branch_pc = bpc;
        if (o_ce && !stall && !flush) begin
            check("pc_order", o_pc, exp_pc);
            check("instr_data", o_instr, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
        end
        if (stall && o_ce && !flush) begin
            chk_hold   = 1'b1;
            hold_pc    = o_pc;
            hold_instr = o_instr;
        end
        if (flush) begin
            chk_ce0    = 1'b1;
            exp_pc     = bpc & 32'hFFFF_FFFC;
            next_fetch = bpc & 32'hFFFF_FFFC;
            if (req && !ack) cur_stale = 1'b1;
        end else if (req && ack && !cur_stale) begin
            next_fetch = next_fetch + 32'd4;
        end
        if (req && !ack) begin
            pending = 1'b1;
            m_cnt++;
        end else begin
            pending = 1'b0;
        end
        @(posedge clk); @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pops;
        logic found;
        i_branch_pc = 32'h0;
        @(negedge clk);

        // 1: zero-wait memory, no stall, from reset.
        fixed_lat = 1;
        do_reset(1'b0);
        check("t1_c0_req", 32'(o_imem_req), 32'd0);
        cycle(1'b0, 1'b0, 32'h0);
        check("t1_c1_req", 32'(o_imem_req), 32'd1);
        check("t1_c1_addr", o_imem_addr, 32'h0);
        check("t1_c1_ce", 32'(o_ce), 32'd0);
        cycle(1'b0, 1'b0, 32'h0);
        check("t1_c2_ce", 32'(o_ce), 32'd1);
        check("t1_c2_pc", o_pc, 32'h0);
        check("t1_c2_addr", o_imem_addr, 32'h4);
        cycle(1'b0, 1'b0, 32'h0);
        check("t1_c3_pc", o_pc, 32'h4);
        check("t1_c3_addr", o_imem_addr, 32'h8);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 32'h0);

        // 2: ack latency 3 -> roughly one instruction every 3 cycles.
        fixed_lat = 3;
        pops = 0;
        for (int i = 0; i < 30; i++) begin
            if (o_ce) pops++;
            cycle(1'b0, 1'b0, 32'h0);
        end
        check("t2_rate", 32'(pops >= 9 && pops <= 11), 32'd1);

        // 3: stall 5 cycles with zero-wait memory: buffer fills, req drops.
        fixed_lat = 1;
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 32'h0);
        check("t3_req_full", 32'(o_imem_req), 32'd0);
        check("t3_ce", 32'(o_ce), 32'd1);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 32'h0);

        // 4: flush to 0x100 while a request to 0x20 is outstanding.
        do_reset(1'b0);
        cycle(1'b0, 1'b1, 32'h20);
        fixed_lat = 3;
        check("t4_req", 32'(o_imem_req), 32'd1);
        check("t4_addr20", o_imem_addr, 32'h20);
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 32'h100);
        fixed_lat = 1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (o_imem_req && !pending) begin
                check("t4_new_addr", o_imem_addr, 32'h100);
                found = 1'b1;
            end else begin
                cycle(1'b0, 1'b0, 32'h0);
            end
        end
        if (!found) check("t4_timeout", 32'd0, 32'd1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 32'h0);

        // 5: flush coincident with an ack and with stall; unaligned target.
        check("t5_req", 32'(o_imem_req), 32'd1);
        cycle(1'b1, 1'b1, 32'h203);
        check("t5_req_after", 32'(o_imem_req), 32'd1);
        check("t5_addr", o_imem_addr, 32'h200);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 32'h0);

        // 6: reset mid-wait with a late ack, then restart at RESET_PC.
        fixed_lat = 4;
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        do_reset(1'b1);
        check("t6_idle_req", 32'(o_imem_req), 32'd0);
        i_imem_ack  = 1'b1;
        i_imem_data = 32'hBAD0_BAD0;
        @(posedge clk); @(negedge clk);
        i_imem_ack = 1'b0;
        check("t6_ce", 32'(o_ce), 32'd0);
        check("t6_nop", o_instr, 32'h0000_0013);
        check("t6_addr", o_imem_addr, 32'h0);
        fixed_lat = 1;
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 32'h0);

        // Randomized traffic: latency 1..4, stalls, flushes (incl. near wrap).
        fixed_lat = 0;
        for (int i = 0; i < 3000; i++) begin
            logic        st, fl;
            logic [31:0] tgt;
            st  = ($urandom_range(0, 3) == 0);
            fl  = ($urandom_range(0, 19) == 0);
            tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 + 32'($urandom_range(0, 3))
                                              : $urandom;
            if ($urandom_range(0, 599) == 0) begin
                do_reset(1'($urandom_range(0, 1)));
            end else begin
                cycle(st, fl, tgt);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
